// File: rtl/btn_event_decoder.sv
// Turns a debounced button level into one-cycle short, double and long press pulses timed in ticks.
// Optional macro BTN_AUTOREPEAT_EN adds repeat_press pulses while a long press is held.
module btn_event_decoder #(
   parameter int unsigned LONG_TICKS   = 8,
   parameter int unsigned GAP_TICKS    = 3,
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned REPEAT_TICKS = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_clean,
   input  logic tick,
   output logic short_press,
   output logic double_press,
   output logic long_press,
   output logic repeat_press,
   output logic busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PRESS1,
      S_WAIT2,
      S_PRESS2,
      S_HOLD
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
`ifdef BTN_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_TICKS - 1);
`else
   // REPEAT_TICKS has no effect without auto-repeat; sink it here.
   logic [31:0] unused_repeat_ticks;
   assign unused_repeat_ticks = 32'(REPEAT_TICKS);
`endif

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             btn_q, btn_d;
   logic             short_q, short_d;
   logic             double_q, double_d;
   logic             long_q, long_d;
`ifdef BTN_AUTOREPEAT_EN
   logic             repeat_q, repeat_d;
`endif
   logic             rise, fall;
   logic             cnt_clr, cnt_inc;

   assign rise = btn_clean & ~btn_q;
   assign fall = ~btn_clean & btn_q;

   always_comb begin
      btn_d    = btn_clean;
      state_d  = state_q;
      short_d  = 1'b0;
      double_d = 1'b0;
      long_d   = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      repeat_d = 1'b0;
`endif
      cnt_clr  = 1'b0;

      // Edges are tested before ticks so an edge always wins a coincidence.
      case (state_q)
         S_IDLE: begin
            if (rise) state_d = S_PRESS1;
         end
         S_PRESS1: begin
            if (fall) begin
               state_d = S_WAIT2;
            end else if (tick && (cnt_q == LONG_LAST)) begin
               long_d  = 1'b1;
               state_d = S_HOLD;
            end
         end
         S_WAIT2: begin
            if (rise) begin
               state_d = S_PRESS2;
            end else if (tick && (cnt_q == GAP_LAST)) begin
               short_d = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_PRESS2: begin
            if (fall) begin
               double_d = 1'b1;
               state_d  = S_IDLE;
            end
         end
         S_HOLD: begin
            if (fall) begin
               state_d = S_IDLE;
`ifdef BTN_AUTOREPEAT_EN
            end else if (tick && (cnt_q == REP_LAST)) begin
               repeat_d = 1'b1;
               cnt_clr  = 1'b1;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase

      cnt_inc = tick && (cnt_q != CNT_MAX);
`ifndef BTN_AUTOREPEAT_EN
      if (state_q == S_HOLD) cnt_inc = 1'b0;
`endif
      if ((state_d != state_q) || cnt_clr) begin
         cnt_d = '0;
      end else if (cnt_inc) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // btn_q resets high so a button held through reset must be released first.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         btn_q    <= 1'b1;
         short_q  <= 1'b0;
         double_q <= 1'b0;
         long_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
         repeat_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         btn_q    <= btn_d;
         short_q  <= short_d;
         double_q <= double_d;
         long_q   <= long_d;
`ifdef BTN_AUTOREPEAT_EN
         repeat_q <= repeat_d;
`endif
      end
   end

   assign short_press  = short_q;
   assign double_press = double_q;
   assign long_press   = long_q;
`ifdef BTN_AUTOREPEAT_EN
   assign repeat_press = repeat_q;
`else
   assign repeat_press = 1'b0;
`endif
   assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_btn_event_decoder.sv
// Self-checking bench for btn_event_decoder: gesture scenarios with tick every 4 clk and an event scoreboard.
module tb_btn_event_decoder;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic btn_clean = 1'b0;
   logic tick = 1'b0;
   logic short_press, double_press, long_press, repeat_press, busy;

   btn_event_decoder dut (
      .clk          (clk),
      .rst          (rst),
      .btn_clean    (btn_clean),
      .tick         (tick),
      .short_press  (short_press),
      .double_press (double_press),
      .long_press   (long_press),
      .repeat_press (repeat_press),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [3:0]  code;
      logic [31:0] at;
   } ev_t;

   localparam logic [3:0] EV_SHORT  = 4'b0001;
   localparam logic [3:0] EV_DOUBLE = 4'b0010;
   localparam logic [3:0] EV_LONG   = 4'b0100;
   localparam logic [3:0] EV_REP    = 4'b1000;

   ev_t exp_q[$];
   ev_t obs_q[$];
   int  n_checks = 0;
   int  n_pass   = 0;

   // One clk step: log any pulse produced by the previous edge, then drive inputs.
   task automatic drive(input logic b, input logic t);
      logic [3:0] ev;
      @(negedge clk);
      ev = {repeat_press, long_press, double_press, short_press};
      if (ev != 4'b0000) obs_q.push_back('{code: ev, at: 32'(cyc)});
      btn_clean = b;
      tick      = t;
   endtask

   // n ticks, one every 4 clk, with the button at level b; expect event c after tick ev_at.
   task automatic ticks(input int n, input logic b, input int ev_at, input logic [3:0] c);
      for (int i = 1; i <= n; i++) begin
         repeat (3) drive(b, 1'b0);
         drive(b, 1'b1);
         if (i == ev_at) exp_q.push_back('{code: c, at: 32'(cyc + 1)});
      end
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if ({short_press, double_press, long_press, repeat_press, busy} !== 5'b0)
         $display("FAIL reset_in: outs=%b need 00000",
                  {short_press, double_press, long_press, repeat_press, busy});
      else n_pass++;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      n_checks++;
      if ({short_press, double_press, long_press, repeat_press, busy} !== 5'b0)
         $display("FAIL reset_out: outs=%b need 00000",
                  {short_press, double_press, long_press, repeat_press, busy});
      else n_pass++;
      $display("test_reset done");
   endtask

   task automatic test_short();
      ev_t o, e;
      drive(1'b1, 1'b0);
      ticks(3, 1'b1, 0, 4'b0);
      drive(1'b0, 1'b0);
      ticks(3, 1'b0, 3, EV_SHORT);
      drive(1'b0, 1'b0);
      n_checks++;
      if ({short_press, busy} !== 2'b10)
         $display("FAIL short_busy: short,busy=%b need 10", {short_press, busy});
      else n_pass++;
      drive(1'b0, 1'b0);
      n_checks++;
      if (short_press !== 1'b0)
         $display("FAIL short_width: short=%b need 0", short_press);
      else n_pass++;
      ticks(2, 1'b0, 0, 4'b0);
      drive(1'b0, 1'b0);
      while (exp_q.size() + obs_q.size() != 0) begin
         o = '0; e = '0;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         if (exp_q.size() != 0) e = exp_q.pop_front();
         n_checks++;
         if (o !== e) $display("FAIL short_sb: got ev=%b@%0d need ev=%b@%0d", o.code, o.at, e.code, e.at);
         else begin n_pass++; $display("short: ev=%b@%0d ok", o.code, o.at); end
      end
   endtask

   task automatic test_double();
      ev_t o, e;
      drive(1'b1, 1'b0);
      ticks(2, 1'b1, 0, 4'b0);
      drive(1'b0, 1'b0);
      ticks(1, 1'b0, 0, 4'b0);
      drive(1'b1, 1'b0);
      ticks(1, 1'b1, 0, 4'b0);
      drive(1'b0, 1'b0);
      exp_q.push_back('{code: EV_DOUBLE, at: 32'(cyc + 1)});
      drive(1'b0, 1'b0);
      n_checks++;
      if ({double_press, short_press, busy} !== 3'b100)
         $display("FAIL double_now: double,short,busy=%b need 100", {double_press, short_press, busy});
      else n_pass++;
      ticks(4, 1'b0, 0, 4'b0);
      drive(1'b0, 1'b0);
      while (exp_q.size() + obs_q.size() != 0) begin
         o = '0; e = '0;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         if (exp_q.size() != 0) e = exp_q.pop_front();
         n_checks++;
         if (o !== e) $display("FAIL double_sb: got ev=%b@%0d need ev=%b@%0d", o.code, o.at, e.code, e.at);
         else begin n_pass++; $display("double: ev=%b@%0d ok", o.code, o.at); end
      end
   endtask

   task automatic test_long();
      ev_t o, e;
      drive(1'b1, 1'b0);
      for (int i = 1; i <= 20; i++) begin
         repeat (3) drive(1'b1, 1'b0);
         drive(1'b1, 1'b1);
         if (i == 8) exp_q.push_back('{code: EV_LONG, at: 32'(cyc + 1)});
`ifdef BTN_AUTOREPEAT_EN
         if (i >= 10 && (i % 2) == 0) exp_q.push_back('{code: EV_REP, at: 32'(cyc + 1)});
`endif
      end
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL long_idle: busy=%b need 0", busy);
      else n_pass++;
      ticks(4, 1'b0, 0, 4'b0);
      drive(1'b0, 1'b0);
      while (exp_q.size() + obs_q.size() != 0) begin
         o = '0; e = '0;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         if (exp_q.size() != 0) e = exp_q.pop_front();
         n_checks++;
         if (o !== e) $display("FAIL long_sb: got ev=%b@%0d need ev=%b@%0d", o.code, o.at, e.code, e.at);
         else begin n_pass++; $display("long: ev=%b@%0d ok", o.code, o.at); end
      end
   endtask

   task automatic test_held_reset();
      ev_t o, e;
      int  busy_cnt;
      @(negedge clk);
      rst = 1'b0;
      btn_clean = 1'b1;
      tick = 1'b0;
      drive(1'b1, 1'b0);
      drive(1'b1, 1'b0);
      rst = 1'b1;
      busy_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         drive(1'b1, (k % 4) == 3);
         if (busy !== 1'b0) busy_cnt++;
      end
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      if (busy !== 1'b0) busy_cnt++;
      n_checks++;
      if (busy_cnt != 0) $display("FAIL held_busy: busy cycles=%0d need 0", busy_cnt);
      else n_pass++;
      drive(1'b1, 1'b0);
      ticks(1, 1'b1, 0, 4'b0);
      drive(1'b0, 1'b0);
      ticks(3, 1'b0, 3, EV_SHORT);
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      while (exp_q.size() + obs_q.size() != 0) begin
         o = '0; e = '0;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         if (exp_q.size() != 0) e = exp_q.pop_front();
         n_checks++;
         if (o !== e) $display("FAIL held_sb: got ev=%b@%0d need ev=%b@%0d", o.code, o.at, e.code, e.at);
         else begin n_pass++; $display("held: ev=%b@%0d ok", o.code, o.at); end
      end
   endtask

   task automatic test_coincide();
      ev_t o, e;
      drive(1'b1, 1'b0);
      ticks(7, 1'b1, 0, 4'b0);
      repeat (3) drive(1'b1, 1'b0);
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b0);
      n_checks++;
      if ({long_press, busy} !== 2'b01)
         $display("FAIL coin_state: long,busy=%b need 01", {long_press, busy});
      else n_pass++;
      ticks(3, 1'b0, 3, EV_SHORT);
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      while (exp_q.size() + obs_q.size() != 0) begin
         o = '0; e = '0;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         if (exp_q.size() != 0) e = exp_q.pop_front();
         n_checks++;
         if (o !== e) $display("FAIL coin_sb: got ev=%b@%0d need ev=%b@%0d", o.code, o.at, e.code, e.at);
         else begin n_pass++; $display("coincide: ev=%b@%0d ok", o.code, o.at); end
      end
   endtask

   task automatic test_reset_mid();
      ev_t o, e;
      drive(1'b1, 1'b0);
      ticks(1, 1'b1, 0, 4'b0);
      drive(1'b0, 1'b0);
      ticks(1, 1'b0, 0, 4'b0);
      drive(1'b0, 1'b0);
      n_checks++;
      if (busy !== 1'b1) $display("FAIL mid_wait2: busy=%b need 1", busy);
      else n_pass++;
      #3 rst = 1'b0;
      #1;
      n_checks++;
      if ({short_press, double_press, long_press, repeat_press, busy} !== 5'b0)
         $display("FAIL mid_async: outs=%b need 00000",
                  {short_press, double_press, long_press, repeat_press, busy});
      else n_pass++;
      #8 rst = 1'b1;
      ticks(4, 1'b0, 0, 4'b0);
      drive(1'b0, 1'b0);
      drive(1'b0, 1'b0);
      n_checks++;
      if (busy !== 1'b0) $display("FAIL mid_idle: busy=%b need 0", busy);
      else n_pass++;
      while (exp_q.size() + obs_q.size() != 0) begin
         o = '0; e = '0;
         if (obs_q.size() != 0) o = obs_q.pop_front();
         if (exp_q.size() != 0) e = exp_q.pop_front();
         n_checks++;
         if (o !== e) $display("FAIL mid_sb: got ev=%b@%0d need ev=%b@%0d", o.code, o.at, e.code, e.at);
         else begin n_pass++; $display("mid: ev=%b@%0d ok", o.code, o.at); end
      end
   endtask

   initial begin
      test_reset();
      test_short();
      test_double();
      test_long();
      test_held_reset();
      test_coincide();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/btn_event_decoder.md
Name: btn_event_decoder

Overview:
- Sits between the debouncer and the LED controller.
- Turns the clean button level into one-cycle gesture events: short press, double press, long press.
- All gesture timing counts strobes on tick, the one-cycle timebase pulse from the clock divider, so it is independent of the clk frequency.
- The LED controller consumes the event pulses to change blink mode.

Parameters:
- LONG_TICKS, 8: ticks a first press must be held before long_press fires.
- GAP_TICKS, 3: ticks after a release in which a second press turns the gesture into a double press.
- CNT_W, 8: width of the internal tick counter. It must hold max(LONG_TICKS, GAP_TICKS, REPEAT_TICKS).
- REPEAT_TICKS, 2: tick period of repeat pulses; used only with BTN_AUTOREPEAT_EN.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-low (0 = reset).
- btn_clean, input, 1: debounced button level, 1 = pressed.
- tick, input, 1: one-clk timebase strobe.
- short_press, output, 1: one-cycle pulse, single short press completed.
- double_press, output, 1: one-cycle pulse, two presses within the gap.
- long_press, output, 1: one-cycle pulse, hold reached LONG_TICKS.
- repeat_press, output, 1: one-cycle pulse, auto-repeat during hold.
- busy, output, 1: high whenever the FSM is not IDLE.

Behaviour:
- Reset (rst=0, async):
  - FSM goes to IDLE; counter = 0; all outputs = 0.
  - Edge register btn_q = 1, so a button held through reset produces no press until it has been released.
- Edge detection:
  - btn_q <= btn_clean every clk.
  - rise = btn_clean & ~btn_q; fall = ~btn_clean & btn_q.
- Outputs are registered. Each event pulse is high for exactly one clk, on the cycle after the deciding edge or tick. At most one event pulse is high in any cycle.
- Counter: cleared on every state entry; increments on tick; saturates at all-ones.
- IDLE:
  - rise -> PRESS1.
- PRESS1:
  - fall -> WAIT2.
  - tick while held with counter == LONG_TICKS-1 -> pulse long_press, go to HOLD.
- WAIT2:
  - rise -> PRESS2.
  - tick with counter == GAP_TICKS-1 and no rise -> pulse short_press, go to IDLE.
- PRESS2:
  - fall -> pulse double_press, go to IDLE.
  - Holding in PRESS2 never produces long_press; it waits for release.
- HOLD:
  - fall -> IDLE, with no additional event.
  - Repeat behaviour is defined under Optional Feature.
- Simultaneous events in one cycle:
  - An edge has priority over tick. For example, fall and the long-threshold tick together in PRESS1 -> WAIT2, no long_press.
  - In WAIT2, rise and the gap-expiry tick together -> PRESS2, no short_press.
- tick held high continuously counts every clk; this is legal and used for simulation speed-up.
- rst asserted mid-gesture aborts it silently, with no pulse.
- busy is combinational from the state register: 0 only in IDLE.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - In HOLD, the counter restarts at 0 on entry.
  - Each tick with counter == REPEAT_TICKS-1 pulses repeat_press and clears the counter.
  - fall exits to IDLE; a fall and a repeat tick in the same cycle give no pulse.
- Not defined:
  - repeat_press is tied to 0.
  - The HOLD counter logic is not synthesised.
  - REPEAT_TICKS is ignored.

Test Plan:
- Defaults, tick every 4 clk:
  - Stimulus: press for 3 ticks, release, stay idle 3 ticks.
  - Required: exactly one short_press, one clk wide, one clk after the 3rd gap tick; busy returns to 0 the same cycle.
- Double press:
  - Stimulus: press 2 ticks, release 1 tick, press 1 tick, release.
  - Required: one double_press one clk after the second fall; no short_press.
- Long press:
  - Stimulus: hold 20 ticks, then release.
  - Required: long_press exactly once, one clk after the 8th tick; no other pulse; IDLE after release.
  - With BTN_AUTOREPEAT_EN: repeat_press on ticks 10, 12, …, 20, six pulses.
- Held through reset:
  - Stimulus: btn_clean=1 while rst deasserts; hold 10 ticks; release.
  - Required: no events and busy=0 throughout; the next full press/gap cycle gives short_press.
- Coincidence:
  - Stimulus: fall on the same clk as the 8th tick in PRESS1.
  - Required: no long_press; short_press after the gap expires.
- Reset mid-gesture:
  - Stimulus: assert rst=0 during WAIT2 for one clk, asynchronous to clk.
  - Required: outputs immediately 0, state IDLE, no pulse after release.
